rggen_indirect_access_sequencer: RTL
====================================

RGGEN_INDIRECT_ACCESS_SEQUENCER -- requirements
Module: rggen_indirect_access_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, bus address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, bus data width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 8, indirect index width, 1..BUS_WIDTH.
REQ-004 SHALL have parameter INDEX_ADDRESS, default 'h00, byte address of the index register.
REQ-005 SHALL have parameter DATA_ADDRESS, default 'h04, byte address of the indirect data register.
REQ-006 SHALL have parameter INDEX_CACHE, default 1; 1 enables skipping a redundant index write.
REQ-007 Ports SHALL be, clock and reset first:
  i_clk  in  1  clock, rising edge.
  i_rst  in  1  reset, asynchronous, active-high.
  i_req_valid  in  1  host request valid.
  o_req_ready  out  1  host request accepted.
  i_req_write  in  1  1 = write, 0 = read.
  i_req_index  in  INDEX_WIDTH  target indirect index.
  i_req_data  in  BUS_WIDTH  write data.
  i_req_strobe  in  BUS_WIDTH/8  byte strobes for the data write.
  o_rsp_valid  out  1  response valid.
  i_rsp_ready  in  1  host accepts response.
  o_rsp_error  out  1  bus error on either phase.
  o_rsp_data  out  BUS_WIDTH  read data; 0 for writes and errors.
  o_bus_valid  out  1  bus access valid.
  o_bus_write  out  1  bus access direction.
  o_bus_address  out  ADDRESS_WIDTH  bus address.
  o_bus_write_data  out  BUS_WIDTH  bus write data.
  o_bus_strobe  out  BUS_WIDTH/8  bus byte strobes.
  i_bus_ready  in  1  bus access complete.
  i_bus_status  in  2  0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR.
  i_bus_read_data  in  BUS_WIDTH  bus read data.

Function
REQ-008 SHALL implement FSM states IDLE, INDEX, DATA, RESP.
REQ-009 o_req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on i_req_valid & o_req_ready, with all request fields latched.
REQ-010 On acceptance, the next state SHALL be DATA if INDEX_CACHE=1, the cache is valid and the cached index equals i_req_index; otherwise it SHALL be INDEX.
REQ-011 In INDEX: o_bus_valid=1, write=1, address=INDEX_ADDRESS, write_data=index zero-extended, strobe all ones.
REQ-012 In DATA: o_bus_valid=1, write=latched write, address=DATA_ADDRESS, write_data/strobe=latched values (strobe 0 for reads).
REQ-013 Bus outputs SHALL stay stable from assertion until the cycle i_bus_ready=1, which completes the access.
REQ-014 An access SHALL be an error when i_bus_status[1]=1; EXOKAY SHALL be treated as success.
REQ-015 INDEX completion without error SHALL load the cache with the index, set it valid, and go to DATA.
REQ-016 INDEX completion with error SHALL clear the cache valid flag, skip DATA, and go to RESP with error=1.
REQ-017 DATA completion SHALL go to RESP, capture error, and capture i_bus_read_data for error-free reads (else 0).
REQ-018 A DATA-phase error SHALL clear the cache valid flag.
REQ-019 In RESP, o_rsp_valid=1 with stable data/error until i_rsp_ready; next state IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-020 o_bus_valid SHALL be 0 in IDLE and RESP; only one bus access SHALL be outstanding.
REQ-021 Min latency with i_bus_ready always 1: accept at cycle 0, INDEX at 1, DATA at 2, o_rsp_valid at 3; cache hit: DATA at 1, o_rsp_valid at 2.
REQ-022 With INDEX_CACHE=0, every request SHALL perform the INDEX phase.

Reset
REQ-023 i_rst=1 SHALL force, asynchronously, state IDLE, cache invalid, cached index 0, and all outputs 0 except o_req_ready=1.
REQ-024 Reset mid-access SHALL drop o_bus_valid immediately and discard the pending request without a response.

Verification
REQ-025 Read index 5, bus ready same cycle, status OKAY, read_data 'hA5A5_0001 -> index write 'h05 @INDEX_ADDRESS, data read @DATA_ADDRESS, rsp data 'hA5A5_0001, error 0 at cycle 3.
REQ-026 Second read, index 5, INDEX_CACHE=1 -> no INDEX access, rsp at cycle 2; repeat with index 6 -> INDEX access performed.
REQ-027 Write 'hDEAD_BEEF, strobe 'b0011, i_bus_ready delayed 4 cycles per phase -> bus fields stable throughout, rsp data 0, error 0.
REQ-028 INDEX phase returns SLVERR -> no DATA access, rsp error 1, data 0; next request to same index performs INDEX.
REQ-029 i_rsp_ready held 0 for 5 cycles -> rsp stable, o_req_ready 0; on release, IDLE next cycle.
REQ-030 Assert i_rst during DATA -> o_bus_valid 0 same cycle, o_rsp_valid 0, o_req_ready 1, cache invalid.

Source files
------------

// File: rtl/rggen_indirect_access_sequencer.sv
// Turns one host request into an index-register write plus a data-register access.
// The index write is skipped when the target index already sits in the index register.
//
// state | meaning
// IDLE  | ready for a host request
// INDEX | writing the target index to the index register
// DATA  | reading or writing the indirect data register
// RESP  | holding the response until the host takes it
module rggen_indirect_access_sequencer #(
    parameter int                     ADDRESS_WIDTH = 8,
    parameter int                     BUS_WIDTH     = 32,
    parameter int                     INDEX_WIDTH   = 8,
    parameter bit [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = 'h00,
    parameter bit [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = 'h04,
    parameter int                     INDEX_CACHE   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [INDEX_WIDTH-1:0]   i_req_index,
    input  logic [BUS_WIDTH-1:0]     i_req_data,
    input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_error,
    output logic [BUS_WIDTH-1:0]     o_rsp_data,
    output logic                     o_bus_valid,
    output logic                     o_bus_write,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [BUS_WIDTH-1:0]     o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
    input  logic                     i_bus_ready,
    input  logic [1:0]               i_bus_status,
    input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INDEX = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e state;
    state_e state_next;

    logic                    req_write;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [BUS_WIDTH-1:0]    req_data;
    logic [STROBE_WIDTH-1:0] req_strobe;
    logic                    cache_valid;
    logic [INDEX_WIDTH-1:0]  cache_index;
    logic                    rsp_error;
    logic [BUS_WIDTH-1:0]    rsp_data;

    logic accept;
    logic cache_hit;
    logic bus_error;

    assign accept    = (state == IDLE) && i_req_valid;
    assign cache_hit = (INDEX_CACHE != 0) && cache_valid && (cache_index == i_req_index);
    // SLVERR and DECERR are errors; EXOKAY counts as success.
    assign bus_error = (i_bus_status == 2'd2) || (i_bus_status == 2'd3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        o_req_ready      = 1'b0;
        o_rsp_valid      = 1'b0;
        o_rsp_error      = 1'b0;
        o_rsp_data       = '0;
        o_bus_valid      = 1'b0;
        o_bus_write      = 1'b0;
        o_bus_address    = '0;
        o_bus_write_data = '0;
        o_bus_strobe     = '0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_next = cache_hit ? DATA : INDEX;
                end
            end
            INDEX: begin
                o_bus_valid                         = 1'b1;
                o_bus_write                         = 1'b1;
                o_bus_address                       = INDEX_ADDRESS;
                o_bus_write_data[INDEX_WIDTH-1:0]   = req_index;
                o_bus_strobe                        = '1;
                if (i_bus_ready) begin
                    state_next = bus_error ? RESP : DATA;
                end
            end
            DATA: begin
                o_bus_valid      = 1'b1;
                o_bus_write      = req_write;
                o_bus_address    = DATA_ADDRESS;
                o_bus_write_data = req_data;
                o_bus_strobe     = req_strobe;
                if (i_bus_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_error = rsp_error;
                o_rsp_data  = rsp_data;
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_write   <= 1'b0;
            req_index   <= '0;
            req_data    <= '0;
            req_strobe  <= '0;
            cache_valid <= 1'b0;
            cache_index <= '0;
            rsp_error   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_write  <= i_req_write;
                        req_index  <= i_req_index;
                        req_data   <= i_req_data;
                        // Reads carry no byte enables on the bus.
                        req_strobe <= i_req_write ? i_req_strobe : '0;
                        rsp_error  <= 1'b0;
                        rsp_data   <= '0;
                    end
                end
                INDEX: begin
                    if (i_bus_ready) begin
                        if (bus_error) begin
                            cache_valid <= 1'b0;
                            rsp_error   <= 1'b1;
                            rsp_data    <= '0;
                        end else begin
                            cache_valid <= 1'b1;
                            cache_index <= req_index;
                        end
                    end
                end
                DATA: begin
                    if (i_bus_ready) begin
                        rsp_error <= bus_error;
                        rsp_data  <= (!bus_error && !req_write) ? i_bus_read_data : '0;
                        // The index register content is unknown after a failed access.
                        if (bus_error) begin
                            cache_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
